bit_serializer: RTL and testbench

Parallel-to-serial front end that feeds the single-bit input of the Detector110 sequence detector. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, with a qualifying valid and a last-bit flag. A programmable idle gap can be inserted between words; with a zero gap, consecutive words form a continuous bit stream.

---
 rtl/bit_serializer_if.sv | 22 ++
 rtl/bit_serializer.sv | 127 ++++++++++++
 tb/tb_bit_serializer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bundle for the serializer: valid/ready word side plus
// the registered serial side that feeds the sequence detector.
interface bit_serializer_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, sout_last
  );

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, sout_last
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one WIDTH-bit word per handshake, shifted out
// one bit per clock with valid/last flags and an optional idle gap per word.
module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input logic              clk,
  input logic              rst,
  bit_serializer_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    GAP_LD   = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic             sout_q, sout_d;
  logic             vld_q, vld_d;
  logic             last_q, last_d;

  logic din_ready;
  logic accept;
  logic on_last;

  assign on_last = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);

  // With no gap, the last-bit cycle doubles as an accept slot so words chain
  // without a bubble; reset gates ready so nothing is captured while held.
  assign din_ready = rst && ((state_q == ST_IDLE) ||
                             ((GAP_CYCLES == 0) && on_last));
  assign accept    = bus.din_valid && din_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    sout_d  = sout_q;
    vld_d   = vld_q;
    last_d  = last_q;

    if (accept) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      vld_d   = 1'b1;
      last_d  = 1'b0;
      if (MSB_FIRST) begin
        sout_d  = bus.din[WIDTH-1];
        shreg_d = {bus.din[WIDTH-2:0], 1'b0};
      end else begin
        sout_d  = bus.din[0];
        shreg_d = {1'b0, bus.din[WIDTH-1:1]};
      end
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (on_last) begin
            sout_d  = 1'b0;
            vld_d   = 1'b0;
            last_d  = 1'b0;
            shreg_d = '0;
            cnt_d   = '0;
            if (GAP_CYCLES > 0) begin
              gap_d   = GAP_LD;
              state_d = ST_GAP;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d  = cnt_q + CNT_ONE;
            last_d = ((cnt_q + CNT_ONE) == CNT_LAST);
            if (MSB_FIRST) begin
              sout_d  = shreg_q[WIDTH-1];
              shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
              sout_d  = shreg_q[0];
              shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
          end
        end
        ST_GAP: begin
          if (gap_q == 4'd0) state_d = ST_IDLE;
          else               gap_d   = gap_q - 4'd1;
        end
        default: begin
          sout_d = 1'b0;
          vld_d  = 1'b0;
          last_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      sout_q  <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      sout_q  <= sout_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

  assign bus.din_ready  = din_ready;
  assign bus.sout       = sout_q;
  assign bus.sout_valid = vld_q;
  assign bus.sout_last  = last_q;
endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench: three serializer builds (gap=2 MSB-first, gap=0 MSB-first,
// gap=0 LSB-first) sharing one clock and reset, checked against hand vectors.
module tb_bit_serializer;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  bit_serializer_if #(.WIDTH(8)) bus_a ();
  bit_serializer_if #(.WIDTH(8)) bus_b ();
  bit_serializer_if #(.WIDTH(8)) bus_c ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_b (.clk(clk), .rst(rst), .bus(bus_b));
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u_c (.clk(clk), .rst(rst), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp16;
  logic [7:0]  exp8;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    bus_a.din = 8'hD6; bus_a.din_valid = 1'b1;
    bus_b.din = 8'h00; bus_b.din_valid = 1'b0;
    bus_c.din = 8'h00; bus_c.din_valid = 1'b0;

    // reset held with valid asserted: nothing accepted, all outputs low
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_sout",  bus_a.sout,       1'b0);
      chk("rst_vld",   bus_a.sout_valid, 1'b0);
      chk("rst_last",  bus_a.sout_last,  1'b0);
      chk("rst_ready", bus_a.din_ready,  1'b0);
    end
    rst = 1'b1;
    #1;
    chk("rel_ready", bus_a.din_ready, 1'b1);

    // single word D6, gap of 2
    step();
    bus_a.din_valid = 1'b0;
    exp8 = 8'b1101_0110;
    for (int i = 0; i < 8; i++) begin
      chk("w1_bit",   bus_a.sout,       exp8[7-i]);
      chk("w1_vld",   bus_a.sout_valid, 1'b1);
      chk("w1_last",  bus_a.sout_last,  (i == 7));
      chk("w1_ready", bus_a.din_ready,  1'b0);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      chk("gap_vld",   bus_a.sout_valid, 1'b0);
      chk("gap_sout",  bus_a.sout,       1'b0);
      chk("gap_ready", bus_a.din_ready,  1'b0);
      step();
    end
    chk("idle_ready", bus_a.din_ready, 1'b1);

    // back-to-back C3,36 with no gap
    chk("b2b_idle_ready", bus_b.din_ready, 1'b1);
    bus_b.din = 8'hC3; bus_b.din_valid = 1'b1;
    step();
    bus_b.din = 8'h36;
    exp16 = 16'b11000011_00110110;
    for (int i = 0; i < 16; i++) begin
      chk("b2b_bit",   bus_b.sout,       exp16[15-i]);
      chk("b2b_vld",   bus_b.sout_valid, 1'b1);
      chk("b2b_last",  bus_b.sout_last,  (i == 7 || i == 15));
      chk("b2b_ready", bus_b.din_ready,  (i == 7 || i == 15));
      step();
      if (i == 7) bus_b.din_valid = 1'b0;
    end
    chk("b2b_end_vld",   bus_b.sout_valid, 1'b0);
    chk("b2b_end_sout",  bus_b.sout,       1'b0);
    chk("b2b_end_ready", bus_b.din_ready,  1'b1);

    // LSB-first 01
    bus_c.din = 8'h01; bus_c.din_valid = 1'b1;
    step();
    bus_c.din_valid = 1'b0;
    exp8 = 8'b1000_0000;
    for (int i = 0; i < 8; i++) begin
      chk("lsb_bit",  bus_c.sout,       exp8[7-i]);
      chk("lsb_vld",  bus_c.sout_valid, 1'b1);
      chk("lsb_last", bus_c.sout_last,  (i == 7));
      step();
    end
    chk("lsb_end_vld", bus_c.sout_valid, 1'b0);

    // busy rejection: FF waits behind 00 and the gap
    bus_a.din = 8'h00; bus_a.din_valid = 1'b1;
    step();
    bus_a.din = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      chk("busy_bit", bus_a.sout,       1'b0);
      chk("busy_vld", bus_a.sout_valid, 1'b1);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      chk("busy_gap_vld", bus_a.sout_valid, 1'b0);
      step();
    end
    chk("busy_idle_ready", bus_a.din_ready, 1'b1);
    step();
    bus_a.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("ff_bit",  bus_a.sout,       1'b1);
      chk("ff_vld",  bus_a.sout_valid, 1'b1);
      chk("ff_last", bus_a.sout_last,  (i == 7));
      step();
    end
    step(); step();
    chk("ff_idle_ready", bus_a.din_ready, 1'b1);

    // reset in the middle of AA, then 81 from a clean start
    bus_a.din = 8'hAA; bus_a.din_valid = 1'b1;
    step();
    bus_a.din_valid = 1'b0;
    exp8 = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      chk("aa_bit", bus_a.sout, exp8[7-i]);
      if (i < 2) step();
    end
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_sout",  bus_a.sout,       1'b0);
    chk("mid_rst_vld",   bus_a.sout_valid, 1'b0);
    chk("mid_rst_last",  bus_a.sout_last,  1'b0);
    chk("mid_rst_ready", bus_a.din_ready,  1'b0);
    step();
    rst = 1'b1;
    bus_a.din = 8'h81; bus_a.din_valid = 1'b1;
    #1;
    chk("post_rst_ready", bus_a.din_ready, 1'b1);
    step();
    bus_a.din_valid = 1'b0;
    exp8 = 8'h81;
    for (int i = 0; i < 8; i++) begin
      chk("w81_bit",  bus_a.sout,       exp8[7-i]);
      chk("w81_vld",  bus_a.sout_valid, 1'b1);
      chk("w81_last", bus_a.sout_last,  (i == 7));
      step();
    end
    chk("w81_end_vld", bus_a.sout_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
